lsq_port_arbiter: RTL and testbench
===================================

Name: lsq_port_arbiter

Overview:
- Shares the single E-grid-to-D-tile memory port among all execution tiles of one core.
- Each E-tile holds a load or store request level-high until it gets a one-cycle ack.
- The arbiter picks one requester round-robin, forwards the latched request to the D-tile, waits for the D-tile ack, then returns load data and hit only to the granted tile.
- Sits in trips_core between the E-tile grid and d_tile, replacing direct shared wiring of the memory port.

Parameters:
- NUM_REQ, 16, number of E-tile requesters (GRID_ROWS*GRID_COLS).
- ADDR_W, 40, memory address width.
- DATA_W, 64, load/store data width.
- LSID_W, 5, load/store ID width (32 LSIDs per block).
- TIMEOUT, 255, BUSY cycles before timeout_err is raised.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  block flush/abort pulse from G-tile
- req_load  in  NUM_REQ  per-tile load request (level)
- req_store  in  NUM_REQ  per-tile store request (level)
- req_lsid  in  NUM_REQ x LSID_W  per-tile LSID
- req_addr  in  NUM_REQ x ADDR_W  per-tile address
- req_wdata  in  NUM_REQ x DATA_W  per-tile store data
- rsp_ack  out  NUM_REQ  one-hot ack back to tiles
- rsp_hit  out  1  hit for the acked tile
- rsp_rdata  out  DATA_W  load data for the acked tile
- d_load_req  out  1  load request to D-tile
- d_store_req  out  1  store request to D-tile
- d_lsid  out  LSID_W  forwarded LSID
- d_addr  out  ADDR_W  forwarded address
- d_wdata  out  DATA_W  forwarded store data
- d_load_data  in  DATA_W  load data from D-tile
- d_hit  in  1  hit from D-tile
- d_ack  in  1  D-tile completion (one-cycle pulse)
- busy  out  1  high when the state is not IDLE
- grant_id  out  $clog2(NUM_REQ)  index of the current grant
- protocol_err  out  1  sticky: one tile raised load and store together
- timeout_err  out  1  sticky: BUSY lasted longer than TIMEOUT

Behaviour:
- All outputs are registered. On rst every output is 0, state = IDLE, rr_ptr = 0, and the wait counter = 0.
- Valid request: req_load[i] | req_store[i].
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Grant the first valid index at or above rr_ptr, wrapping modulo NUM_REQ.
  - Latch that index, its LSID, address, data and op. Go to BUSY.
  - If no request is valid, stay in IDLE.
  - flush in IDLE has no effect.
- BUSY:
  - Drive d_load_req or d_store_req level-high with the latched payload.
  - The wait counter increments each cycle.
  - When d_ack=1:
    - Capture d_load_data and d_hit.
    - Deassert d_*_req on the next cycle.
    - rr_ptr becomes grant+1, wrapping NUM_REQ-1 to 0.
    - Go to RESP.
  - When the counter reaches TIMEOUT, set timeout_err (sticky) and keep waiting.
  - A flush while in BUSY cannot abandon the D-tile transaction. It sets an internal drop flag instead.
- RESP:
  - For one cycle, drive rsp_ack[grant]=1 with rsp_rdata and rsp_hit.
  - If the drop flag is set, rsp_ack stays all-zero. Clear the flag.
  - Go to IDLE.
  - The requester must drop its request by the cycle after rsp_ack. RESP exists so the old request is never re-granted.
- Latency:
  - Request sampled in IDLE at cycle 0 -> d_*_req high at cycle 1.
  - d_ack at cycle k -> rsp_ack at cycle k+1.
  - Minimum 3 cycles per transaction when d_ack arrives at cycle 1.
- A tile with both load and store asserted: forward it as a store and set protocol_err (sticky).
- The payload is latched at grant time. Changes to the requester's inputs while BUSY are ignored.
- d_ack outside BUSY is ignored.
- rsp_rdata is valid for loads only; for stores it holds 0.
- rst mid-transaction: the FSM returns to IDLE immediately and d_*_req drops. The D-tile is reset by the same rst.

Decomposition:
- Package lsq_arb_pkg:
  - LSID_W, ADDR_W and DATA_W defaults.
  - The mem_req_t struct (op, lsid, addr, wdata).
  - The arb_state_e enum (IDLE, BUSY, RESP).
- Sub-module rr_pick:
  - Combinational rotating-priority encoder.
  - Inputs: the valid vector and rr_ptr.
  - Outputs: the grant index and any_valid.

Test Plan:
- Single load from tile 5, D-tile acks at cycle 3 with data 0xDEAD_BEEF and hit=1:
  - d_load_req is high on cycles 1-3 with tile 5's address.
  - rsp_ack[5] is high at cycle 4 with rsp_rdata=0xDEADBEEF.
  - busy drops at cycle 5.
- Tiles 0, 3 and 15 request continuously, D-tile acks after 1 cycle:
  - Grant order is 0, 3, 15, 0 (wrap).
  - No tile receives two acks for one request.
- Tile 2 stores, then changes req_addr while BUSY:
  - d_addr holds the value latched at grant.
  - rsp_rdata is 0 and rsp_ack[2] pulses once.
- flush asserted in BUSY, D-tile acks 4 cycles later:
  - d_store_req stays high until d_ack.
  - rsp_ack stays all-zero; FSM is back in IDLE after RESP.
- Tile 7 raises load and store together:
  - d_store_req is forwarded and protocol_err goes to 1 and stays there.
- No d_ack for 256 cycles:
  - timeout_err goes to 1 and busy stays 1.
  - rst then clears all outputs and the state to IDLE on the next edge.

Source files
------------

// File: rtl/lsq_arb_pkg.sv
// rtl/lsq_arb_pkg.sv - shared widths, request payload and FSM state for the LSQ port arbiter
package lsq_arb_pkg;
    localparam int LSID_W = 5;
    localparam int ADDR_W = 40;
    localparam int DATA_W = 64;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } mem_op_e;

    typedef struct packed {
        mem_op_e             op;
        logic [LSID_W-1:0]   lsid;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;
endpackage

// File: rtl/lsq_port_arbiter_if.sv
// rtl/lsq_port_arbiter_if.sv - E-tile request bus and D-tile memory port bundles
interface lsq_req_if #(
    parameter int NUM_REQ = 16,
    parameter int LSID_W  = lsq_arb_pkg::LSID_W,
    parameter int ADDR_W  = lsq_arb_pkg::ADDR_W,
    parameter int DATA_W  = lsq_arb_pkg::DATA_W
);
    logic [NUM_REQ-1:0]             req_load;
    logic [NUM_REQ-1:0]             req_store;
    logic [NUM_REQ-1:0][LSID_W-1:0] req_lsid;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             rsp_ack;
    logic                           rsp_hit;
    logic [DATA_W-1:0]              rsp_rdata;

    modport master (
        output req_load, req_store, req_lsid, req_addr, req_wdata,
        input  rsp_ack, rsp_hit, rsp_rdata
    );
    modport slave (
        input  req_load, req_store, req_lsid, req_addr, req_wdata,
        output rsp_ack, rsp_hit, rsp_rdata
    );
endinterface

interface lsq_dmem_if #(
    parameter int LSID_W = lsq_arb_pkg::LSID_W,
    parameter int ADDR_W = lsq_arb_pkg::ADDR_W,
    parameter int DATA_W = lsq_arb_pkg::DATA_W
);
    logic              d_load_req;
    logic              d_store_req;
    logic [LSID_W-1:0] d_lsid;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_load_data;
    logic              d_hit;
    logic              d_ack;

    modport master (
        output d_load_req, d_store_req, d_lsid, d_addr, d_wdata,
        input  d_load_data, d_hit, d_ack
    );
    modport slave (
        input  d_load_req, d_store_req, d_lsid, d_addr, d_wdata,
        output d_load_data, d_hit, d_ack
    );
endinterface

// File: rtl/lsq_port_arbiter_rr_pick.sv
// rtl/lsq_port_arbiter_rr_pick.sv - rotating-priority encoder: first valid index at or above ptr
module rr_pick #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any_valid
);
    logic [IW:0] sum;

    // Scan offsets from far to near so the nearest valid index is written last.
    always_comb begin
        grant     = '0;
        sum       = '0;
        any_valid = |valid;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            if (valid[sum[IW-1:0]]) begin
                grant = sum[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/lsq_port_arbiter.sv
// rtl/lsq_port_arbiter.sv - round-robin arbiter sharing the single D-tile memory port among E-tiles
module lsq_port_arbiter
    import lsq_arb_pkg::*;
#(
    parameter int NUM_REQ = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    lsq_req_if.slave                   tiles,
    lsq_dmem_if.master                 dmem,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       protocol_err,
    output logic                       timeout_err
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e          state_q, state_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]       grant_q, grant_d;
    mem_req_t            req_q, req_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                drop_q, drop_d;
    logic [NUM_REQ-1:0]  rsp_ack_q, rsp_ack_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                d_load_req_q, d_load_req_d;
    logic                d_store_req_q, d_store_req_d;
    logic                busy_q, busy_d;
    logic                perr_q, perr_d;
    logic                terr_q, terr_d;

    logic [GW-1:0]       pick;
    logic                any_valid;

    rr_pick #(.N(NUM_REQ), .IW(GW)) u_pick (
        .valid     (tiles.req_load | tiles.req_store),
        .ptr       (rr_ptr_q),
        .grant     (pick),
        .any_valid (any_valid)
    );

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        req_d         = req_q;
        cnt_d         = cnt_q;
        drop_d        = drop_q;
        rsp_ack_d     = '0;
        rsp_hit_d     = 1'b0;
        rsp_rdata_d   = '0;
        d_load_req_d  = d_load_req_q;
        d_store_req_d = d_store_req_q;
        perr_d        = perr_q;
        terr_d        = terr_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    // Store wins when a tile raises both ops.
                    grant_d       = pick;
                    req_d.op      = tiles.req_store[pick] ? OP_STORE : OP_LOAD;
                    req_d.lsid    = tiles.req_lsid[pick];
                    req_d.addr    = tiles.req_addr[pick];
                    req_d.wdata   = tiles.req_wdata[pick];
                    d_store_req_d = tiles.req_store[pick];
                    d_load_req_d  = ~tiles.req_store[pick];
                    perr_d        = perr_q | (tiles.req_load[pick] & tiles.req_store[pick]);
                    cnt_d         = '0;
                    drop_d        = 1'b0;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CW'(TIMEOUT)) begin
                    terr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                drop_d = drop_q | flush;
                if (dmem.d_ack) begin
                    d_load_req_d  = 1'b0;
                    d_store_req_d = 1'b0;
                    rr_ptr_d      = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d       = RESP;
                    if (!drop_d) begin
                        rsp_ack_d[grant_q] = 1'b1;
                        rsp_hit_d          = dmem.d_hit;
                        rsp_rdata_d        = (req_q.op == OP_LOAD) ? dmem.d_load_data : '0;
                    end
                end
            end
            RESP: begin
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            req_q         <= '0;
            cnt_q         <= '0;
            drop_q        <= 1'b0;
            rsp_ack_q     <= '0;
            rsp_hit_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            d_load_req_q  <= 1'b0;
            d_store_req_q <= 1'b0;
            busy_q        <= 1'b0;
            perr_q        <= 1'b0;
            terr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            req_q         <= req_d;
            cnt_q         <= cnt_d;
            drop_q        <= drop_d;
            rsp_ack_q     <= rsp_ack_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_rdata_q   <= rsp_rdata_d;
            d_load_req_q  <= d_load_req_d;
            d_store_req_q <= d_store_req_d;
            busy_q        <= busy_d;
            perr_q        <= perr_d;
            terr_q        <= terr_d;
        end
    end

    assign tiles.rsp_ack    = rsp_ack_q;
    assign tiles.rsp_hit    = rsp_hit_q;
    assign tiles.rsp_rdata  = rsp_rdata_q;
    assign dmem.d_load_req  = d_load_req_q;
    assign dmem.d_store_req = d_store_req_q;
    assign dmem.d_lsid      = req_q.lsid;
    assign dmem.d_addr      = req_q.addr;
    assign dmem.d_wdata     = req_q.wdata;
    assign busy             = busy_q;
    assign grant_id         = grant_q;
    assign protocol_err     = perr_q;
    assign timeout_err      = terr_q;
endmodule

// File: tb/tb_lsq_port_arbiter.sv
// tb/tb_lsq_port_arbiter.sv - directed and randomized checks of lsq_port_arbiter against a behavioural model
module tb_lsq_port_arbiter;
    localparam int N  = 16;
    localparam int TO = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       busy;
    logic [3:0] grant_id;
    logic       perr;
    logic       terr;

    always #5 clk = ~clk;

    lsq_req_if  tiles ();
    lsq_dmem_if dmem ();

    lsq_port_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .tiles        (tiles),
        .dmem         (dmem),
        .busy         (busy),
        .grant_id     (grant_id),
        .protocol_err (perr),
        .timeout_err  (terr)
    );

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: phase 0 = free, 1 = waiting on D-tile, 2 = answering.
    int          m_phase, m_ptr, m_g, m_cnt;
    bit          m_store, m_drop, m_perr, m_terr, m_hit;
    logic [4:0]  m_lsid;
    logic [39:0] m_addr;
    logic [63:0] m_wdata, m_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int found;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_g = 0; m_cnt = 0;
            m_store = 0; m_drop = 0; m_perr = 0; m_terr = 0; m_hit = 0;
            m_lsid = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else if (m_phase == 0) begin
            found = -1;
            for (int k = 0; k < N; k++) begin
                if (found < 0 && (tiles.req_load[(m_ptr + k) % N] || tiles.req_store[(m_ptr + k) % N]))
                    found = (m_ptr + k) % N;
            end
            if (found >= 0) begin
                m_g     = found;
                m_store = tiles.req_store[found];
                if (tiles.req_load[found] && tiles.req_store[found]) m_perr = 1;
                m_lsid  = tiles.req_lsid[found];
                m_addr  = tiles.req_addr[found];
                m_wdata = tiles.req_wdata[found];
                m_cnt   = 0;
                m_drop  = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_cnt >= TO) m_terr = 1;
            m_cnt++;
            if (flush) m_drop = 1;
            if (dmem.d_ack) begin
                m_rdata = m_store ? 64'h0 : dmem.d_load_data;
                m_hit   = dmem.d_hit;
                m_ptr   = (m_g + 1) % N;
                m_phase = 2;
            end
        end else begin
            m_phase = 0;
            m_drop  = 0;
        end
    endtask

    task automatic compare();
        logic [15:0] exp_ack;
        exp_ack = (m_phase == 2 && !m_drop) ? (16'd1 << m_g) : 16'd0;
        chk("busy", busy, m_phase != 0);
        chk("d_load_req", dmem.d_load_req, m_phase == 1 && !m_store);
        chk("d_store_req", dmem.d_store_req, m_phase == 1 && m_store);
        chk("rsp_ack", tiles.rsp_ack, exp_ack);
        chk("protocol_err", perr, m_perr);
        chk("timeout_err", terr, m_terr);
        if (m_phase != 0) chk("grant_id", grant_id, m_g);
        if (m_phase == 1) begin
            chk("d_addr", dmem.d_addr, m_addr);
            chk("d_lsid", dmem.d_lsid, m_lsid);
            if (m_store) chk("d_wdata", dmem.d_wdata, m_wdata);
        end
        if (exp_ack != 0) begin
            chk("rsp_rdata", tiles.rsp_rdata, m_rdata);
            chk("rsp_hit", tiles.rsp_hit, m_hit);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        compare();
    endtask

    task automatic clear_inputs();
        flush = 0;
        tiles.req_load = '0;
        tiles.req_store = '0;
        tiles.req_lsid = '0;
        tiles.req_addr = '0;
        tiles.req_wdata = '0;
        dmem.d_ack = 0;
        dmem.d_load_data = '0;
        dmem.d_hit = 0;
    endtask

    task automatic drain();
        clear_inputs();
        dmem.d_ack = 1;
        for (int c = 0; c < 10 && m_phase != 0; c++) tick();
        dmem.d_ack = 0;
        tick();
    endtask

    int          order[4];
    int          n_acks, idx;
    bit          reraise[N];
    bit          pend[N];
    logic [39:0] a2;

    initial begin
        rst = 1;
        clear_inputs();
        tick();
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_ack", tiles.rsp_ack, 0);
        chk("rst_d_req", {dmem.d_load_req, dmem.d_store_req}, 0);
        chk("rst_d_addr", dmem.d_addr, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_errs", {perr, terr}, 0);

        // Single load from tile 5, D-tile acks on cycle 3.
        tiles.req_load[5] = 1;
        tiles.req_addr[5] = 40'h12_3456_7890;
        tiles.req_lsid[5] = 5'd9;
        tick();
        chk("t1_c1_load_req", dmem.d_load_req, 1);
        chk("t1_c1_addr", dmem.d_addr, 40'h12_3456_7890);
        chk("t1_c1_grant", grant_id, 5);
        tick();
        tick();
        chk("t1_c3_load_req", dmem.d_load_req, 1);
        dmem.d_ack = 1;
        dmem.d_load_data = 64'hDEAD_BEEF;
        dmem.d_hit = 1;
        tick();
        chk("t1_c4_ack", tiles.rsp_ack, 16'h0020);
        chk("t1_c4_rdata", tiles.rsp_rdata, 64'hDEAD_BEEF);
        chk("t1_c4_hit", tiles.rsp_hit, 1);
        chk("t1_c4_load_req", dmem.d_load_req, 0);
        dmem.d_ack = 0;
        tiles.req_load[5] = 0;
        tick();
        chk("t1_c5_busy", busy, 0);

        // Tiles 0, 3, 15 request continuously; D-tile acks immediately.
        rst = 1;
        clear_inputs();
        tick();
        rst = 0;
        tiles.req_load[0] = 1;
        tiles.req_load[3] = 1;
        tiles.req_load[15] = 1;
        dmem.d_ack = 1;
        n_acks = 0;
        for (int c = 0; c < 40 && n_acks < 4; c++) begin
            for (int i = 0; i < N; i++) begin
                if (reraise[i]) tiles.req_load[i] = 1;
                reraise[i] = 0;
            end
            tick();
            if (tiles.rsp_ack != 0) begin
                chk("t2_onehot", $countones(tiles.rsp_ack), 1);
                for (int i = 0; i < N; i++) if (tiles.rsp_ack[i]) idx = i;
                order[n_acks] = idx;
                n_acks++;
                tiles.req_load[idx] = 0;
                reraise[idx] = 1;
            end
        end
        chk("t2_ack_count", n_acks, 4);
        chk("t2_order0", order[0], 0);
        chk("t2_order1", order[1], 3);
        chk("t2_order2", order[2], 15);
        chk("t2_order3", order[3], 0);
        for (int i = 0; i < N; i++) reraise[i] = 0;
        drain();

        // Tile 2 store, payload changes while BUSY.
        a2 = 40'hAB_CDEF_0123;
        tiles.req_store[2] = 1;
        tiles.req_addr[2] = a2;
        tiles.req_wdata[2] = 64'h0123_4567_89AB_CDEF;
        tick();
        chk("t3_store_req", dmem.d_store_req, 1);
        tiles.req_addr[2] = ~a2;
        tiles.req_wdata[2] = 64'h5555;
        tick();
        chk("t3_addr_held", dmem.d_addr, a2);
        chk("t3_wdata_held", dmem.d_wdata, 64'h0123_4567_89AB_CDEF);
        dmem.d_ack = 1;
        dmem.d_load_data = 64'h1111;
        dmem.d_hit = 1;
        tick();
        chk("t3_ack", tiles.rsp_ack, 16'h0004);
        chk("t3_rdata_zero", tiles.rsp_rdata, 0);
        dmem.d_ack = 0;
        tiles.req_store[2] = 0;
        n_acks = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (tiles.rsp_ack[2]) n_acks++;
        end
        chk("t3_no_second_ack", n_acks, 0);

        // Flush during BUSY: transaction completes but no ack is returned.
        tiles.req_store[9] = 1;
        tiles.req_addr[9] = 40'h99;
        tick();
        flush = 1;
        tick();
        flush = 0;
        chk("t4_c2_store_req", dmem.d_store_req, 1);
        tick();
        tick();
        tick();
        chk("t4_c5_store_req", dmem.d_store_req, 1);
        dmem.d_ack = 1;
        tick();
        chk("t4_resp_no_ack", tiles.rsp_ack, 0);
        chk("t4_resp_store_req", dmem.d_store_req, 0);
        dmem.d_ack = 0;
        tiles.req_store[9] = 0;
        tick();
        chk("t4_idle", busy, 0);

        // Tile 7 raises load and store together.
        tiles.req_load[7] = 1;
        tiles.req_store[7] = 1;
        tick();
        chk("t5_store_req", dmem.d_store_req, 1);
        chk("t5_load_req", dmem.d_load_req, 0);
        tick();
        chk("t5_perr", perr, 1);
        dmem.d_ack = 1;
        tick();
        tiles.req_load[7] = 0;
        tiles.req_store[7] = 0;
        dmem.d_ack = 0;
        tick();
        tick();
        chk("t5_perr_sticky", perr, 1);

        // No D-tile ack: timeout, then reset clears everything.
        tiles.req_load[1] = 1;
        tiles.req_addr[1] = 40'h77;
        tick();
        for (int c = 0; c < 260; c++) tick();
        chk("t6_terr", terr, 1);
        chk("t6_busy", busy, 1);
        chk("t6_load_req", dmem.d_load_req, 1);
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_d_req", {dmem.d_load_req, dmem.d_store_req}, 0);
        chk("t6_rst_errs", {perr, terr}, 0);
        chk("t6_rst_grant", grant_id, 0);
        chk("t6_rst_addr", dmem.d_addr, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (m_phase == 2) begin
                tiles.req_load[m_g] = 0;
                tiles.req_store[m_g] = 0;
                pend[m_g] = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 8 == 0)) begin
                    pend[i] = 1;
                    if ($urandom % 2 == 1) tiles.req_store[i] = 1;
                    else tiles.req_load[i] = 1;
                end
                tiles.req_lsid[i]  = 5'($urandom);
                tiles.req_addr[i]  = 40'({$urandom, $urandom});
                tiles.req_wdata[i] = {$urandom, $urandom};
            end
            dmem.d_ack       = ($urandom % 3 == 0);
            dmem.d_load_data = {$urandom, $urandom};
            dmem.d_hit       = 1'($urandom);
            flush            = ($urandom % 16 == 0);
            rst              = ($urandom % 400 == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
